// File: rtl/ps2_kbd_pkg.sv
// PS/2 keyboard shared constants and types.
// Scan-code set 2 prefixes, key codes and the decoder state enum.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] ASCII_LF  = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } dec_state_t;

endpackage

// File: rtl/ps2_scancode_to_ascii.sv
// Set-2 scan code to ASCII lookup, combinational.
// Returns 0 for codes with no printable mapping.
module ps2_scancode_to_ascii
  import ps2_kbd_pkg::*;
(
  input  logic [7:0] scan,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] base;

  // Base (lower-case) mapping
  always_comb begin
    base = 8'h00;
    case (scan)
      8'h1C: base = "a";
      8'h32: base = "b";
      8'h21: base = "c";
      8'h23: base = "d";
      8'h24: base = "e";
      8'h2B: base = "f";
      8'h34: base = "g";
      8'h33: base = "h";
      8'h43: base = "i";
      8'h3B: base = "j";
      8'h42: base = "k";
      8'h4B: base = "l";
      8'h3A: base = "m";
      8'h31: base = "n";
      8'h44: base = "o";
      8'h4D: base = "p";
      8'h15: base = "q";
      8'h2D: base = "r";
      8'h1B: base = "s";
      8'h2C: base = "t";
      8'h3C: base = "u";
      8'h2A: base = "v";
      8'h1D: base = "w";
      8'h22: base = "x";
      8'h35: base = "y";
      8'h1A: base = "z";
      8'h45: base = "0";
      8'h16: base = "1";
      8'h1E: base = "2";
      8'h26: base = "3";
      8'h25: base = "4";
      8'h2E: base = "5";
      8'h36: base = "6";
      8'h3D: base = "7";
      8'h3E: base = "8";
      8'h46: base = "9";
      SC_ENTER: base = ASCII_LF;
      8'h66: base = 8'h08;
      8'h29: base = 8'h20;
      default: base = 8'h00;
    endcase
  end

  // Shift folds lower-case letters to upper case only
  always_comb begin
    ascii = base;
    if (shift && base >= "a" && base <= "z")
      ascii = base - 8'h20;
  end

endmodule

// File: rtl/ps2_char_queue.sv
// PS/2 and emoji button char source feeding a FWFT FIFO.
// Keyboard decoder, emoji release detect, queue and handshake.
module ps2_char_queue
  import ps2_kbd_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter int         NUM_EMOJI  = 4,
  parameter logic [7:0] EMOJI_BASE = 8'd128,
  parameter bit         REPEAT_EN  = 1'b0,
  localparam int        ADDR_W     = $clog2(DEPTH)
) (
  input  logic                 fpga_clock,
  input  logic                 reset,
  input  logic [7:0]           scan_code,
  input  logic                 scan_strobe,
  input  logic [NUM_EMOJI-1:0] emoji,
  input  logic                 char_ready,
  output logic                 char_valid,
  output logic [7:0]           char_data,
  output logic                 char_is_enter,
  output logic [ADDR_W:0]      fifo_count,
  output logic                 overflow
);

  dec_state_t state, state_n;
  logic       shift, shift_n;
  logic [7:0] held, held_n;
  logic       kb_push, kb_push_n;
  logic [7:0] kb_data, kb_data_n;
  logic [7:0] ascii;

  logic [NUM_EMOJI-1:0] em_s1, em_s2, em_s3;
  logic [NUM_EMOJI-1:0] em_pend, em_sel;
  logic                 em_hit, em_grant;
  logic [2:0]           em_idx;
  logic [7:0]           em_data;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              full, pop, wr_en;
  logic [7:0]        push_data;

  ps2_scancode_to_ascii u_lut (
    .scan  (scan_code),
    .shift (shift),
    .ascii (ascii)
  );

  // Decoder state, shift/held tracking and keyboard push stage
  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= 1'b0;
      held    <= 8'h00;
      kb_push <= 1'b0;
      kb_data <= 8'h00;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      held    <= held_n;
      kb_push <= kb_push_n;
      kb_data <= kb_data_n;
    end
  end

  // Decoder next state; only a strobe moves it
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    held_n    = held;
    kb_push_n = 1'b0;
    kb_data_n = kb_data;
    if (scan_strobe) begin
      unique case (state)
        IDLE: begin
          if (scan_code == SC_BREAK) begin
            state_n = BRK;
          end else if (scan_code == SC_EXT) begin
            state_n = EXT;
          end else if (scan_code == SC_LSHIFT ||
                       scan_code == SC_RSHIFT) begin
            shift_n = 1'b1;
          end else if (REPEAT_EN || scan_code != held) begin
            held_n = scan_code;
            if (ascii != 8'h00) begin
              kb_push_n = 1'b1;
              kb_data_n = ascii;
            end
          end
        end
        BRK: begin
          if (scan_code == SC_LSHIFT ||
              scan_code == SC_RSHIFT)
            shift_n = 1'b0;
          if (scan_code == held)
            held_n = 8'h00;
          state_n = IDLE;
        end
        EXT: begin
          if (scan_code == SC_BREAK) begin
            state_n = EXT_BRK;
          end else begin
            if (scan_code == SC_ENTER) begin
              kb_push_n = 1'b1;
              kb_data_n = ASCII_LF;
            end
            state_n = IDLE;
          end
        end
        EXT_BRK: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Emoji synchroniser, edge history and pending flags
  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      em_s1   <= '0;
      em_s2   <= '0;
      em_s3   <= '0;
      em_pend <= '0;
    end else begin
      em_s1   <= emoji;
      em_s2   <= em_s1;
      em_s3   <= em_s2;
      em_pend <= (em_pend | (em_s3 & ~em_s2)) &
                 ~(em_grant ? em_sel : '0);
    end
  end

  // Lowest pending emoji wins a free FIFO slot
  always_comb begin
    em_hit = 1'b0;
    em_idx = 3'd0;
    em_sel = '0;
    for (int i = NUM_EMOJI - 1; i >= 0; i--) begin
      if (em_pend[i]) begin
        em_hit    = 1'b1;
        em_idx    = 3'(i);
        em_sel    = '0;
        em_sel[i] = 1'b1;
      end
    end
  end

  assign em_grant  = em_hit && !kb_push && !full;
  assign em_data   = EMOJI_BASE + {5'd0, em_idx};
  assign push_data = kb_push ? kb_data : em_data;

  assign full  = (fifo_count == (ADDR_W + 1)'(DEPTH));
  assign pop   = char_valid && char_ready;
  assign wr_en = (kb_push && (!full || pop)) || em_grant;

  assign char_valid    = (fifo_count != '0);
  assign char_data     = mem[rd_ptr];
  assign char_is_enter = char_valid && (char_data == ASCII_LF);

  // FIFO storage write port
  always_ff @(posedge fpga_clock) begin
    if (wr_en)
      mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)
        fifo_count <= fifo_count + 1'b1;
      else if (pop && !wr_en)
        fifo_count <= fifo_count - 1'b1;
      if (kb_push && full && !pop)
        overflow <= 1'b1;
    end
  end

endmodule
